// File: rtl/uart_pkg.sv
// Shared UART definitions: Tx state encoding, parity codes and frame data width.
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP1,
      TX_STOP2
   } tx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   // 2'b11 is treated as "no parity", same as PAR_NONE
   function automatic logic parity_en(input logic [1:0] par);
      return (par == PAR_ODD) || (par == PAR_EVEN);
   endfunction

endpackage

// File: rtl/uart_tx_shift_reg.sv
// Tx data shifter: parallel load, right shift, and XOR of the bits shifted out since load.
module uart_tx_shift_reg
   import uart_pkg::*;
(
   input  logic              glb_clk,
   input  logic              glb_rstn,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] data,
   output logic              bit0,
   output logic              bit1,
   output logic              parity
);

   logic [DATA_W-1:0] q;

   always_ff @(posedge glb_clk or negedge glb_rstn) begin
      if (!glb_rstn) begin
         q      <= '0;
         parity <= 1'b0;
      end else if (load) begin
         q      <= data;
         parity <= 1'b0;
      end else if (shift) begin
         q      <= {1'b0, q[DATA_W-1:1]};
         parity <= parity ^ q[0];
      end
   end

   assign bit0 = q[0];
   assign bit1 = q[1];

endmodule

// File: rtl/uart_tx_module.sv
// UART transmitter: pops bytes from the Tx FIFO and serialises start/data/parity/stop bits.
// Optional line-break feature enabled by defining UART_TX_BREAK_EN.
//
// state     | meaning
// TX_IDLE   | line idle (high, or low while break is held)
// TX_START  | start bit (0) on the line
// TX_DATA   | data bits LSB first, bit_cnt selects which
// TX_PARITY | parity bit of the latched byte
// TX_STOP1  | first stop bit; may chain straight into the next frame
// TX_STOP2  | second stop bit when two are configured
module uart_tx_module
   import uart_pkg::*;
(
   input  logic              glb_clk,
   input  logic              glb_rstn,
   input  logic              baud_ctrl_prescalerout,
   input  logic              Cfg_ctrl_stopbit,
   input  logic [1:0]        Cfg_ctrl_paritybit,
   input  logic              Cfg_ctrl_Tx_en,
   input  logic              FIFO_ctrl_empty,
   input  logic [DATA_W-1:0] FIFO_Tx_data_payload,
`ifdef UART_TX_BREAK_EN
   input  logic              Cfg_ctrl_break,
`endif
   output logic              UART_ctrl_FIFO_r_en,
   output logic              usr_data_sendbit,
   output logic              UART_ctrl_Tx_busy
);

   tx_state_t  state;
   logic [2:0] bit_cnt;
   logic       stop2_q;
   logic [1:0] par_q;
   logic       start_ok;
   logic       frame_end;
   logic       pop;
   logic       idle_line;
   logic       sr_shift;
   logic       sr_bit0;
   logic       sr_bit1;
   logic       sr_par;

`ifdef UART_TX_BREAK_EN
   logic brk_q;

   // brk_q holds off a frame for one cycle so the line shows high after a break release
   assign start_ok  = Cfg_ctrl_Tx_en & ~FIFO_ctrl_empty & ~Cfg_ctrl_break & ~brk_q;
   assign idle_line = ~Cfg_ctrl_break;

   always_ff @(posedge glb_clk or negedge glb_rstn) begin
      if (!glb_rstn) brk_q <= 1'b0;
      else           brk_q <= Cfg_ctrl_break;
   end
`else
   assign start_ok  = Cfg_ctrl_Tx_en & ~FIFO_ctrl_empty;
   assign idle_line = 1'b1;
`endif

   assign frame_end = ((state == TX_STOP1) && !stop2_q) || (state == TX_STOP2);
   assign pop       = glb_rstn & baud_ctrl_prescalerout & start_ok &
                      ((state == TX_IDLE) | frame_end);
   assign sr_shift  = baud_ctrl_prescalerout & (state == TX_DATA);

   assign UART_ctrl_FIFO_r_en = pop;

   uart_tx_shift_reg u_shift (
      .glb_clk  (glb_clk),
      .glb_rstn (glb_rstn),
      .load     (pop),
      .shift    (sr_shift),
      .data     (FIFO_Tx_data_payload),
      .bit0     (sr_bit0),
      .bit1     (sr_bit1),
      .parity   (sr_par)
   );

   // The line register is loaded with the value of the state being entered,
   // so each bit appears the cycle after its tick.
   always_ff @(posedge glb_clk or negedge glb_rstn) begin
      if (!glb_rstn) begin
         state             <= TX_IDLE;
         bit_cnt           <= 3'd0;
         stop2_q           <= 1'b0;
         par_q             <= PAR_NONE;
         usr_data_sendbit  <= 1'b1;
         UART_ctrl_Tx_busy <= 1'b0;
      end else if (pop) begin
         state             <= TX_START;
         bit_cnt           <= 3'd0;
         stop2_q           <= Cfg_ctrl_stopbit;
         par_q             <= Cfg_ctrl_paritybit;
         usr_data_sendbit  <= 1'b0;
         UART_ctrl_Tx_busy <= 1'b1;
      end else if (state == TX_IDLE) begin
         usr_data_sendbit  <= idle_line;
         UART_ctrl_Tx_busy <= 1'b0;
      end else if (baud_ctrl_prescalerout) begin
         case (state)
            TX_START: begin
               state            <= TX_DATA;
               usr_data_sendbit <= sr_bit0;
            end
            TX_DATA: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (parity_en(par_q)) begin
                     state            <= TX_PARITY;
                     usr_data_sendbit <= sr_par ^ sr_bit0 ^ (par_q == PAR_ODD);
                  end else begin
                     state            <= TX_STOP1;
                     usr_data_sendbit <= 1'b1;
                  end
               end else begin
                  usr_data_sendbit <= sr_bit1;
               end
            end
            TX_PARITY: begin
               state            <= TX_STOP1;
               usr_data_sendbit <= 1'b1;
            end
            TX_STOP1: begin
               if (stop2_q) begin
                  state <= TX_STOP2;
               end else begin
                  state             <= TX_IDLE;
                  usr_data_sendbit  <= idle_line;
                  UART_ctrl_Tx_busy <= 1'b0;
               end
            end
            TX_STOP2: begin
               state             <= TX_IDLE;
               usr_data_sendbit  <= idle_line;
               UART_ctrl_Tx_busy <= 1'b0;
            end
            default: begin
               state             <= TX_IDLE;
               usr_data_sendbit  <= 1'b1;
               UART_ctrl_Tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_module.sv
// Self-checking bench for uart_tx_module: directed frame table, enable/reset sequences,
// and randomized traffic compared against a frame-level reference model.
module tb_uart_tx_module;

   logic       glb_clk = 1'b0;
   logic       glb_rstn = 1'b0;
   logic       tick = 1'b0;
   logic       stopbit = 1'b0;
   logic [1:0] par = 2'b00;
   logic       en = 1'b0;
   logic       empty = 1'b1;
   logic [7:0] payload = 8'h00;
   logic       r_en;
   logic       line;
   logic       busy;
`ifdef UART_TX_BREAK_EN
   logic       brk = 1'b0;
`endif

   uart_tx_module dut (
      .glb_clk                (glb_clk),
      .glb_rstn               (glb_rstn),
      .baud_ctrl_prescalerout (tick),
      .Cfg_ctrl_stopbit       (stopbit),
      .Cfg_ctrl_paritybit     (par),
      .Cfg_ctrl_Tx_en         (en),
      .FIFO_ctrl_empty        (empty),
      .FIFO_Tx_data_payload   (payload),
`ifdef UART_TX_BREAK_EN
      .Cfg_ctrl_break         (brk),
`endif
      .UART_ctrl_FIFO_r_en    (r_en),
      .usr_data_sendbit       (line),
      .UART_ctrl_Tx_busy      (busy)
   );

   always #5 glb_clk = ~glb_clk;

   typedef struct {
      logic       tick;
      logic       en;
      logic       empty;
      logic       stop2;
      logic [1:0] par;
      logic [7:0] data;
      logic       r_en;
      logic       line;
      logic       busy;
   } samp_t;

   typedef struct {
      logic [7:0] d0;
      logic [7:0] d1;
      int         nbytes;
      logic       stop2;
      logic [1:0] par;
   } vec_t;

   samp_t      tr[$];
   logic [7:0] fifo_q[$];
   bit         rec_on = 1'b0;
   bit         pop_pend = 1'b0;
   int         period = 16;
   int         tick_cnt = 0;
   int         checks = 0;
   int         errors = 0;

   // Stimulus driver: FIFO front-end, baud strobe, and one trace record per cycle.
   initial begin
      forever begin
         @(negedge glb_clk);
         if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
         pop_pend = 1'b0;
         tick_cnt = (tick_cnt + 1 >= period) ? 0 : tick_cnt + 1;
         tick = (tick_cnt == 0);
         #1;
         empty   = (fifo_q.size() == 0);
         payload = empty ? 8'h00 : fifo_q[0];
         #1;
         if (rec_on) tr.push_back('{tick, en, empty, stopbit, par, payload, r_en, line, busy});
         if (r_en === 1'b1) pop_pend = 1'b1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", what, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge glb_clk);
   endtask

   function automatic void build_frame(input logic [7:0] d, input logic [1:0] p, input logic s2,
                                       output bit [11:0] fb, output int n);
      int ones;
      fb = '0;
      for (int i = 0; i < 8; i++) fb[i+1] = d[i];
      n = 9;
      ones = $countones(d);
      if (p == 2'b01) begin fb[n] = (ones % 2 == 0); n++; end
      else if (p == 2'b10) begin fb[n] = (ones % 2 == 1); n++; end
      fb[n] = 1'b1; n++;
      if (s2) begin fb[n] = 1'b1; n++; end
   endfunction

   // Frame-level reference: a frame of n bits starting at a pop tick occupies the next n tick intervals.
   task automatic model_check(input string name);
      bit        active = 1'b0;
      int        bi = 0;
      int        n = 0;
      bit [11:0] fb = '0;
      bit        mline = 1'b1;
      bit        mbusy = 1'b0;
      bit        epop;
      for (int c = 0; c < tr.size(); c++) begin
         epop = 1'b0;
         if (tr[c].tick) begin
            if (active) begin
               bi++;
               if (bi == n) active = 1'b0;
            end
            if (!active && tr[c].en && !tr[c].empty) begin
               build_frame(tr[c].data, tr[c].par, tr[c].stop2, fb, n);
               active = 1'b1;
               bi = 0;
               epop = 1'b1;
            end
         end
         chk($sformatf("%s r_en @%0d", name, c), tr[c].r_en, epop);
         chk($sformatf("%s line @%0d", name, c), tr[c].line, mline);
         chk($sformatf("%s busy @%0d", name, c), tr[c].busy, mbusy);
         mline = active ? fb[bi] : 1'b1;
         mbusy = active;
      end
   endtask

   function automatic int count_pops();
      int n = 0;
      for (int i = 0; i < tr.size(); i++) if (tr[i].r_en === 1'b1) n++;
      return n;
   endfunction

   // Compare the line in each bit interval from the first pop with a written-out bit string.
   task automatic check_seq(input string name, input string seq);
      int p = -1;
      int t[$];
      int len = seq.len();
      for (int i = 0; i < tr.size() && p < 0; i++) if (tr[i].r_en === 1'b1) p = i;
      chk({name, " pop seen"}, (p >= 0), 1);
      if (p < 0) return;
      for (int c = p; c < tr.size(); c++) if (tr[c].tick) t.push_back(c);
      chk({name, " trace long enough"}, (t.size() > len) && (t[len] + 1 < tr.size()), 1);
      if (!((t.size() > len) && (t[len] + 1 < tr.size()))) return;
      for (int k = 0; k < len; k++)
         chk($sformatf("%s bit %0d", name, k), tr[t[k]+1].line, (seq[k] == "1") ? 1 : 0);
      chk({name, " busy at last tick"}, tr[t[len]].busy, 1);
      chk({name, " busy after last tick"}, tr[t[len]+1].busy, 0);
      chk({name, " line idle after frame"}, tr[t[len]+1].line, 1);
   endtask

   task automatic wait_pop(input string name);
      int k = 0;
      while (k < 64 && !(tr.size() > 0 && tr[tr.size()-1].r_en === 1'b1)) begin
         cycles(1);
         k++;
      end
      chk({name, " pop within bound"}, (k < 64), 1);
   endtask

   task automatic wait_ticks(input int n);
      int seen = 0;
      int guard = 0;
      while (seen < n && guard < 400) begin
         cycles(1);
         guard++;
         if (tr.size() > 0 && tr[tr.size()-1].tick) seen++;
      end
   endtask

   vec_t  vecs[7];
   string seqs[7];

   initial begin
      vecs[0] = '{8'hA5, 8'h00, 1, 1'b0, 2'b00}; seqs[0] = "0101001011";
      vecs[1] = '{8'h07, 8'h00, 1, 1'b0, 2'b10}; seqs[1] = "01110000011";
      vecs[2] = '{8'h07, 8'h00, 1, 1'b0, 2'b01}; seqs[2] = "01110000001";
      vecs[3] = '{8'h3C, 8'h00, 1, 1'b1, 2'b11}; seqs[3] = "00011110011";
      vecs[4] = '{8'h81, 8'h00, 1, 1'b1, 2'b01}; seqs[4] = "010000001111";
      vecs[5] = '{8'hFF, 8'h00, 1, 1'b0, 2'b10}; seqs[5] = "01111111101";
      vecs[6] = '{8'h55, 8'hAA, 2, 1'b1, 2'b00}; seqs[6] = "0101010101100101010111";

      // Reset: data queued and enabled, yet nothing may pop and the line stays idle.
      en = 1'b1;
      fifo_q.push_back(8'hE7);
      cycles(20);
      #3;
      chk("reset line", line, 1);
      chk("reset busy", busy, 0);
      chk("reset r_en", r_en, 0);
      chk("reset no pop", fifo_q.size(), 1);
      @(negedge glb_clk);
      en = 1'b0;
      fifo_q.delete();
      glb_rstn = 1'b1;
      cycles(20);

      for (int v = 0; v < 7; v++) begin
         par     = vecs[v].par;
         stopbit = vecs[v].stop2;
         en      = 1'b1;
         period  = 16;
         tr.delete();
         rec_on  = 1'b1;
         fifo_q.push_back(vecs[v].d0);
         if (vecs[v].nbytes == 2) fifo_q.push_back(vecs[v].d1);
         cycles(16 * (seqs[v].len() + 3));
         rec_on = 1'b0;
         check_seq($sformatf("vec%0d", v), seqs[v]);
         chk($sformatf("vec%0d pops", v), count_pops(), vecs[v].nbytes);
         model_check($sformatf("vec%0d", v));
      end

      // Enable dropped while bit 3 of 0x3C is on the line, second byte waiting.
      par = 2'b00; stopbit = 1'b0; en = 1'b1;
      tr.delete();
      rec_on = 1'b1;
      fifo_q.push_back(8'h3C);
      fifo_q.push_back(8'h99);
      wait_pop("en_drop");
      wait_ticks(4);
      en = 1'b0;
      cycles(300);
      rec_on = 1'b0;
      chk("en_drop pops", count_pops(), 1);
      chk("en_drop fifo left", fifo_q.size(), 1);
      chk("en_drop line idle", tr[tr.size()-1].line, 1);
      chk("en_drop busy low", tr[tr.size()-1].busy, 0);
      model_check("en_drop");
      fifo_q.delete();

      // Reset during DATA, then the next queued byte goes out cleanly.
      en = 1'b1;
      tr.delete();
      rec_on = 1'b1;
      fifo_q.push_back(8'h5A);
      fifo_q.push_back(8'hC3);
      wait_pop("rst");
      wait_ticks(3);
      rec_on = 1'b0;
      glb_rstn = 1'b0;
      #3;
      chk("rst line high", line, 1);
      chk("rst busy low", busy, 0);
      cycles(40);
      #3;
      chk("rst no pop", fifo_q.size(), 1);
      chk("rst r_en low", r_en, 0);
      @(negedge glb_clk);
      glb_rstn = 1'b1;
      tr.delete();
      rec_on = 1'b1;
      cycles(16 * 13);
      rec_on = 1'b0;
      check_seq("rst_resume", "0110000111");
      chk("rst_resume pops", count_pops(), 1);
      model_check("rst_resume");
      chk("rst_resume fifo empty", fifo_q.size(), 0);

      // Random traffic, enable toggling and config changes, then drain.
      for (int r = 0; r < 4; r++) begin
         period = $urandom_range(1, 6);
         tr.delete();
         rec_on = 1'b1;
         for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0 && fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 79) == 0) begin
               par     = 2'($urandom);
               stopbit = 1'($urandom);
            end
            cycles(1);
         end
         en = 1'b1;
         cycles(450);
         rec_on = 1'b0;
         model_check($sformatf("rand%0d", r));
         chk($sformatf("rand%0d drained", r), fifo_q.size(), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
